parity_rx: RTL and testbench

Serial receiver and parity checker for 32-bit words protected by the team's even-parity generator. Accepts a framed bit stream on a single line: start bit, 32 data bits LSB first, parity bit, stop bit. Reassembles the word, recomputes the XOR of all 32 bits and compares it with the received parity bit. Hands the word to downstream logic over a valid/ready handshake with parity, framing and overrun flags.

---
 rtl/parity_pkg.sv | 28 ++
 rtl/parity_rx_sync.sv | 25 ++
 rtl/parity_rx.sv | 184 ++++++++++++++++++
 tb/tb_parity_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// parity_pkg: shared definitions for the 32-bit even-parity link.
// Holds the word width, the receiver FSM state encoding and the parity
// function used by both the generator and the receiver, so both ends of
// the link compute parity from one definition.
package parity_pkg;

  // Width of the protected word.
  localparam int DATA_W = 32;

  // Width of the data-bit index (counts 0..DATA_W-1).
  localparam int IDX_W = 5;

  // Receiver frame FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } prx_state_t;

  // XOR reduction of the word. The transmitted parity bit equals this value,
  // so XORing it with the received parity bit yields 1 on a mismatch.
  function automatic logic calc_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/parity_rx_sync.sv
// parity_rx_sync: two-flop synchronizer for the serial line.
// Both flops reset to 1 so that the idle-high line does not look like a
// start bit while reset releases. Only instantiated by parity_rx when
// PARITY_RX_SYNC_EN is defined.
module parity_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/parity_rx.sv
// parity_rx: serial receiver and even-parity checker for 32-bit words.
// Frame on rx: start (0), 32 data bits LSB first, parity bit, stop (1).
// Each bit is sampled at its centre; the reassembled word is handed out on a
// valid/ready port together with parity (perr), framing (ferr) and overrun
// (ovr) flags. The word is delivered even when a flag is set.
//
// Build option: define PARITY_RX_SYNC_EN to pass rx through a two-flop
// synchronizer (adds two cycles of latency). Without it, rx must already be
// synchronous to clk and is used directly.
module parity_rx
  import parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        perr,
  output logic        ferr,
  output logic        ovr,
  output logic        busy
);

  // Half a bit period (floor) positions the start sample mid-bit; every later
  // sample is a whole bit period after the previous one, so it stays mid-bit.
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  // Line sample seen by the FSM.
  logic rxs;

`ifdef PARITY_RX_SYNC_EN
  parity_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );
`else
  assign rxs = rx;
`endif

  prx_state_t        state;
  prx_state_t        state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] sreg;
  logic              p_bit;

  // Decoded per-cycle strobes.
  logic sample;     // a bit-centre sample is taken this cycle
  logic shift_en;   // sample is a data bit
  logic par_en;     // sample is the parity bit
  logic load;       // sample is the stop bit: publish the word

  // Next-state logic and sample strobes.
  always_comb begin
    state_nx = state;
    sample   = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxs) state_nx = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          sample   = 1'b1;
          // A line that is high again at mid-start-bit was only a glitch.
          state_nx = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          sample   = 1'b1;
          shift_en = 1'b1;
          if (idx == IDX_LAST) state_nx = PARITY;
        end
      end
      PARITY: begin
        if (cnt == BIT_LAST) begin
          sample   = 1'b1;
          par_en   = 1'b1;
          state_nx = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          sample   = 1'b1;
          load     = 1'b1;
          // Back to IDLE immediately so a following start bit with no idle
          // gap is still caught.
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Bit timer: restarts on every state change and after every sample, so each
  // period is counted from a known origin regardless of CLKS_PER_BIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (sample || (state_nx != state) || (state == IDLE)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Data-bit index: cleared while idle, advanced once per data sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (state == IDLE) begin
      idx <= '0;
    end else if (shift_en) begin
      idx <= idx + IDX_W'(1);
    end
  end

  // Shift register and parity capture. Not reset: all 32 positions are
  // overwritten by every complete frame before they are published, so an
  // aborted frame can never leak out.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      sreg <= {rxs, sreg[DATA_W-1:1]};
    end
    if (par_en) begin
      p_bit <= rxs;
    end
  end

  // Output word and flags, loaded together on the stop sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      ovr      <= 1'b0;
    end else if (load) begin
      out_data <= sreg;
      perr     <= calc_parity(sreg) ^ p_bit;
      ferr     <= ~rxs;
      // Overrun only if the previous word is still pending and not being
      // taken this very cycle.
      ovr      <= out_valid & ~out_ready;
    end
  end

  // Valid flag: a new load wins over a simultaneous acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_parity_rx.sv
// tb_parity_rx: self-checking bench for parity_rx with CLKS_PER_BIT = 4.
// Frames are built bit by bit from a word, a parity bit and a stop bit. The
// reference model predicts, per frame, the edge at which the word appears
// and the flag values, and tracks the pending/accepted state of the output
// from the bench's own out_ready drive.
module tb_parity_rx;

  localparam int CPB      = 4;
  localparam int H        = CPB / 2;
  localparam int LOAD_LAT = H + 34 * CPB;  // edges from t0 to the stop sample

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        perr;
  logic        ferr;
  logic        ovr;
  logic        busy;

  parity_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .perr      (perr),
    .ferr      (ferr),
    .ovr       (ovr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Edge counter: after posedge number k, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // out_ready as seen by the DUT on each edge.
  logic rdy_e = 1'b0;
  always @(posedge clk) rdy_e <= out_ready;

  typedef struct {
    int          at_edge;
    logic [31:0] data;
    logic        perr;
    logic        ferr;
  } exp_t;

  exp_t q[$];
  logic mvalid = 1'b0;

  // Reference model of the output port, evaluated mid-cycle after each edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      mvalid = 1'b0;
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].at_edge == cyc) begin
        e = q.pop_front();
        chk("ovr", 32'(ovr), 32'(mvalid & ~rdy_e));
        mvalid = 1'b1;
        chk("data", out_data, e.data);
        chk("perr", 32'(perr), 32'(e.perr));
        chk("ferr", 32'(ferr), 32'(e.ferr));
      end else if (rdy_e) begin
        mvalid = 1'b0;
      end
      chk("valid", 32'(out_valid), 32'(mvalid));
    end
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) step();
  endtask

  // Send one frame (called just after an edge) followed by gap idle cycles.
  task automatic send_frame(input logic [31:0] d, input logic p, input logic stp, input int gap);
    exp_t e;
    e.at_edge = cyc + 1 + LOAD_LAT;
    e.data    = d;
    e.perr    = (^d) ^ p;
    e.ferr    = ~stp;
    q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 32; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(stp);
    rx = 1'b1;
    repeat (gap) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  out_data,          32'h0);
    chk({tag, "_valid"}, 32'(out_valid),    32'h0);
    chk({tag, "_perr"},  32'(perr),         32'h0);
    chk({tag, "_ferr"},  32'(ferr),         32'h0);
    chk({tag, "_ovr"},   32'(ovr),          32'h0);
    chk({tag, "_busy"},  32'(busy),         32'h0);
  endtask

  initial begin
    int          busy_n;
    logic [31:0] d;
    logic        p;
    logic        stp;
    int          gap;

    rst       = 1'b1;
    rx        = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    step();
    rst = 1'b0;
    repeat (3) step();

    // Clean frame; the model checks out_valid low before and high exactly
    // at the stop-sample edge.
    send_frame(32'hDEADBEEF, 1'b0, 1'b1, 5);

    // Parity mismatch, then matching parity.
    send_frame(32'h00000001, 1'b0, 1'b1, 3);
    send_frame(32'h00000001, 1'b1, 1'b1, 3);

    // Framing error with correct parity; extra idle absorbs the low stop bit.
    send_frame(32'h12345678, ^32'h12345678, 1'b0, 10);

    // One-cycle glitch on the line.
    rx = 1'b0;
    step();
    rx = 1'b1;
    busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
    end
    chk("glitch_busy", busy_n, H);
    step();
    repeat (4) step();

    // Back-to-back frames with nobody accepting.
    out_ready = 1'b0;
    send_frame(32'hAAAAAAAA, ^32'hAAAAAAAA, 1'b1, 0);
    send_frame(32'h55555555, ^32'h55555555, 1'b1, 6);
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("ovr_hold", 32'(ovr), 32'h1);
    chk("data_hold", out_data, 32'h55555555);
    step();

    // Reset in the middle of data bit 10, then a clean frame.
    d = 32'h0F0F_3C3C;
    drive_bit(1'b0);
    for (int i = 0; i < 10; i++) drive_bit(d[i]);
    rx = d[10];
    repeat (2) step();
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    step();
    rx = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (5) step();
    send_frame(32'h0000FFFF, ^32'h0000FFFF, 1'b1, 4);

    // Randomized frames, flags and back-pressure.
    for (int n = 0; n < 20; n++) begin
      d         = $urandom;
      p         = ($urandom_range(0, 3) != 0) ? (^d) : ~(^d);
      stp       = ($urandom_range(0, 9) != 0);
      gap       = stp ? int'($urandom_range(0, 4)) : 8;
      out_ready = $urandom_range(0, 1);
      send_frame(d, p, stp, gap);
    end
    out_ready = 1'b1;
    repeat (10) step();
    chk("pending_frames", 32'(q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
